// File: rtl/obi_wb_pkg.sv
// Shared types and sizing helpers for the OBI-to-Wishbone bridge.
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

  // A limit of 0 disables the timeout; the counter still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int SEL_WIDTH      = sel_width(DEF_DATA_WIDTH);
  localparam int CNT_WIDTH      = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts Wishbone cycles spent waiting for a slave; flags the last allowed cycle.
module bus_timeout_counter
  import obi_wb_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] MAX_COUNT = CW'(LIMIT);

  logic [CW-1:0] r_count;

  // Saturates at LIMIT so a long stall can never wrap back to a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != MAX_COUNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = enable && (r_count == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/obi_wb_bridge.sv
// OBI responder to Wishbone classic initiator: one outstanding transfer,
// registered response, bus timeout reported as an OBI error.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            obi_req_i,
  output logic                            obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]           obi_addr_i,
  input  logic                            obi_we_i,
  input  logic [sel_width(DATA_WIDTH)-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]           obi_wdata_i,
  output logic                            obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]           obi_rdata_o,
  output logic                            obi_err_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [sel_width(DATA_WIDTH)-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]           wb_addr_o,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i
);

  localparam int SW = sel_width(DATA_WIDTH);

  bridge_state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [SW-1:0]         r_sel;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_in_bus, w_accept, w_bus_ack, w_bus_err, w_timeout, w_done;

  assign w_in_bus  = (r_state == BUS);
  // Gating with rst keeps gnt low while the bridge is held in reset.
  assign w_accept  = obi_req_i && !rst && !w_in_bus;
  assign w_bus_err = w_in_bus && wb_err_i;
  assign w_bus_ack = w_in_bus && wb_ack_i && !wb_err_i;
  assign w_done    = w_bus_err || w_bus_ack || w_timeout;

  bus_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_accept),
    .enable (w_in_bus),
    .expired(w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUS;
      BUS:     if (w_done)   w_next = RESP;
      RESP:    w_next = w_accept ? BUS : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are latched at grant; the response is captured when BUS ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= obi_addr_i;
        r_we    <= obi_we_i;
        r_sel   <= obi_be_i;
        r_wdata <= obi_wdata_i;
      end
      if (w_in_bus && w_done) begin
        r_err   <= !w_bus_ack;
        r_rdata <= (w_bus_ack && !r_we) ? wb_data_i : '0;
      end
    end
  end

  assign obi_gnt_o    = w_accept;
  assign obi_rvalid_o = (r_state == RESP);
  assign obi_rdata_o  = r_rdata;
  assign obi_err_o    = r_err;
  assign wb_cyc_o     = w_in_bus;
  assign wb_stb_o     = w_in_bus;
  assign wb_we_o      = r_we;
  assign wb_sel_o     = r_sel;
  assign wb_addr_o    = r_addr;
  assign wb_data_o    = r_wdata;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge with a transaction-level reference model.
module tb_obi_wb_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: responds on the sl_wait-th cycle (0-based) of each Wishbone cycle.
  logic        sl_ack, sl_err, sl_by_addr, late_ack, sl_prev, sl_fire;
  int          sl_wait, sl_idx;
  logic [31:0] sl_data;

  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = 32'hBAD0_BAD0;
    sl_prev = 1'b0; sl_idx = 0;
    forever begin
      @(posedge clk); #1;
      sl_fire = 1'b0;
      if (wb_cyc_o) begin
        sl_idx  = sl_prev ? sl_idx + 1 : 0;
        sl_fire = (sl_idx == sl_wait);
      end
      sl_prev   = wb_cyc_o;
      wb_ack_i  = (sl_fire && sl_ack) || late_ack;
      wb_err_i  = sl_fire && sl_err;
      wb_data_i = sl_fire ? (sl_by_addr ? ~wb_addr_o : sl_data) : 32'hBAD0_BAD0;
    end
  end

  // Reference model state and observation logs.
  logic        m_busy, m_resp, m_err, m_we, n_resp;
  int          m_waits;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  int          cyc_no, cyc_cnt;
  int          gnt_log[$];
  int          rv_log[$];
  logic [31:0] rvd_log[$];
  logic        rve_log[$];
  logic        seen_we;
  logic [3:0]  seen_sel;
  logic [31:0] seen_addr, seen_data;

  initial begin
    m_busy = 0; m_resp = 0; m_err = 0; m_we = 0; m_waits = 0;
    m_rdata = 0; m_addr = 0; m_wdata = 0; m_be = 0; cyc_no = 0; cyc_cnt = 0;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (rst) begin
        m_busy = 0;
        m_resp = 0;
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_wdata", wb_data_o, 0);
        chk("rst_we_sel", {wb_we_o, wb_sel_o}, 0);
        chk("rst_rdata_err", {obi_rdata_o[30:0], obi_err_o}, 0);
      end
      chk("gnt", obi_gnt_o, obi_req_i && !m_busy && !rst);
      chk("cyc", wb_cyc_o, m_busy);
      chk("stb", wb_stb_o, m_busy);
      chk("rvalid", obi_rvalid_o, m_resp);
      if (m_busy) begin
        chk("wb_addr", wb_addr_o, m_addr);
        chk("wb_we", wb_we_o, m_we);
        chk("wb_sel", wb_sel_o, m_be);
        chk("wb_data", wb_data_o, m_wdata);
      end
      if (m_resp) begin
        chk("rdata", obi_rdata_o, m_rdata);
        chk("err", obi_err_o, m_err);
      end
      if (obi_gnt_o) gnt_log.push_back(cyc_no);
      if (wb_cyc_o) begin
        cyc_cnt++;
        seen_we = wb_we_o; seen_sel = wb_sel_o; seen_addr = wb_addr_o; seen_data = wb_data_o;
      end
      if (obi_rvalid_o) begin
        rv_log.push_back(cyc_no);
        rvd_log.push_back(obi_rdata_o);
        rve_log.push_back(obi_err_o);
      end
      // Advance the transaction to the next cycle.
      if (!rst) begin
        n_resp = 0;
        if (m_busy) begin
          if (wb_err_i) begin
            n_resp = 1; m_err = 1; m_rdata = 0;
          end else if (wb_ack_i) begin
            n_resp = 1; m_err = 0; m_rdata = m_we ? 32'h0 : wb_data_i;
          end else if (m_waits + 1 == TO) begin
            n_resp = 1; m_err = 1; m_rdata = 0;
          end else begin
            m_waits++;
          end
          if (n_resp) m_busy = 0;
        end else if (obi_req_i) begin
          m_busy = 1; m_waits = 0;
          m_addr = obi_addr_i; m_we = obi_we_i; m_be = obi_be_i; m_wdata = obi_wdata_i;
        end
        m_resp = n_resp;
      end
    end
  end

  task automatic clear_logs();
    gnt_log.delete(); rv_log.delete(); rvd_log.delete(); rve_log.delete();
    cyc_cnt = 0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] be,
                        input logic [31:0] d);
    int k;
    obi_req_i = 1; obi_addr_i = a; obi_we_i = w; obi_be_i = be; obi_wdata_i = d;
    k = 0;
    @(negedge clk);
    while (!obi_gnt_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_granted", obi_gnt_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_req();
    obi_req_i = 0; obi_addr_i = 32'hFFFF_FFF0; obi_we_i = 0; obi_be_i = 0; obi_wdata_i = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_single(input string nm, input int lat, input logic [31:0] d, input logic e);
    chk({nm, "_rv_count"}, rv_log.size(), 1);
    chk({nm, "_gnt_count"}, gnt_log.size(), 1);
    if (rv_log.size() >= 1 && gnt_log.size() >= 1) begin
      chk({nm, "_latency"}, rv_log[0] - gnt_log[0], lat);
      chk({nm, "_rdata"}, rvd_log[0], d);
      chk({nm, "_err"}, rve_log[0], e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; late_ack = 0; idle_req();
    sl_ack = 1; sl_err = 0; sl_by_addr = 0; sl_wait = 0; sl_data = 0;
    wait_cyc(3);
    rst = 0;
    wait_cyc(2);

    // Read with two wait states.
    clear_logs();
    sl_wait = 2; sl_data = 32'hDEAD_BEEF;
    do_req(32'h0000_0010, 0, 4'hF, 0);
    idle_req();
    wait_cyc(8);
    chk_single("read2ws", 4, 32'hDEAD_BEEF, 0);
    chk("read2ws_cyc_cycles", cyc_cnt, 3);

    // Zero-wait write.
    clear_logs();
    sl_wait = 0; sl_data = 32'hFFFF_0000;
    do_req(32'h0000_0020, 1, 4'b0011, 32'h1234_5678);
    idle_req();
    wait_cyc(6);
    chk_single("write", 2, 32'h0, 0);
    chk("write_we", seen_we, 1);
    chk("write_sel", seen_sel, 4'b0011);
    chk("write_data", seen_data, 32'h1234_5678);
    chk("write_addr", seen_addr, 32'h0000_0020);

    // Three back-to-back reads with req held high.
    clear_logs();
    sl_wait = 0; sl_by_addr = 1;
    do_req(32'h0000_0100, 0, 4'hF, 0);
    do_req(32'h0000_0104, 0, 4'hF, 0);
    do_req(32'h0000_0108, 0, 4'hF, 0);
    idle_req();
    wait_cyc(6);
    chk("b2b_gnt_count", gnt_log.size(), 3);
    chk("b2b_rv_count", rv_log.size(), 3);
    if (gnt_log.size() == 3 && rv_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("b2b_gnt_spacing", gnt_log[i] - gnt_log[0], 2 * i);
        chk("b2b_rv_latency", rv_log[i] - gnt_log[i], 2);
        chk("b2b_rdata", rvd_log[i], ~(32'h0000_0100 + 32'(4 * i)));
      end
    end
    sl_by_addr = 0;

    // Silent slave: timeout after TO cycles, then a stray ack.
    clear_logs();
    sl_ack = 0; sl_err = 0;
    do_req(32'h0000_0030, 0, 4'hF, 0);
    idle_req();
    wait_cyc(12);
    chk_single("timeout", TO + 1, 32'h0, 1);
    chk("timeout_cyc_cycles", cyc_cnt, TO);
    @(posedge clk);
    late_ack = 1;
    @(posedge clk);
    late_ack = 0;
    wait_cyc(4);
    chk("late_ack_no_rvalid", rv_log.size(), 1);

    // ack and err together: error wins.
    clear_logs();
    sl_ack = 1; sl_err = 1; sl_wait = 1; sl_data = 32'hCAFE_F00D;
    do_req(32'h0000_0040, 0, 4'hF, 0);
    idle_req();
    wait_cyc(6);
    chk_single("ack_err", 3, 32'h0, 1);

    // Reset in the middle of a bus cycle.
    clear_logs();
    sl_ack = 0; sl_err = 0; sl_wait = 0;
    do_req(32'h0000_0050, 0, 4'hF, 0);
    idle_req();
    wait_cyc(2);
    #1;
    rst = 1; obi_req_i = 1;
    #1;
    chk("async_rst_cyc", wb_cyc_o, 0);
    chk("async_rst_stb", wb_stb_o, 0);
    chk("async_rst_gnt", obi_gnt_o, 0);
    chk("async_rst_rvalid", obi_rvalid_o, 0);
    @(posedge clk); #1;
    obi_req_i = 0;
    rst = 0;
    wait_cyc(12);
    chk("rst_no_rvalid", rv_log.size(), 0);

    clear_logs();
    sl_ack = 1; sl_wait = 0; sl_data = 32'h55AA_1234;
    do_req(32'h0000_0060, 0, 4'hF, 0);
    idle_req();
    wait_cyc(5);
    chk_single("after_rst", 2, 32'h55AA_1234, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
